// File: rtl/vram_pixel_store.sv
// Multi-plane video RAM: pipelined pixel-addressed scan read port, masked valid/ready host
// write port, and a clear engine that fills the whole frame with one colour.
module vram_pixel_store #(
  parameter int H_RES          = 128,
  parameter int V_RES          = 96,
  parameter int BPP            = 1,
  parameter int CHANNELS       = 3,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int X_W           = $clog2(H_RES),
  localparam int Y_W           = $clog2(V_RES),
  localparam int PW            = BPP * CHANNELS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rd_en,
  input  logic [X_W-1:0]      rd_x,
  input  logic [Y_W-1:0]      rd_y,
  output logic                rd_valid,
  output logic [PW-1:0]       rd_pixel,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [X_W-1:0]      wr_x,
  input  logic [Y_W-1:0]      wr_y,
  input  logic [CHANNELS-1:0] wr_mask,
  input  logic [PW-1:0]       wr_pixel,
  output logic                wr_err,
  input  logic                clear_req,
  input  logic [PW-1:0]       clear_colour,
  output logic                clear_busy,
  output logic                clear_done
);

  localparam int DEPTH  = H_RES * V_RES;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  function automatic logic in_range(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (int'(x) < H_RES) && (int'(y) < V_RES);
  endfunction

  function automatic logic [ADDR_W-1:0] to_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return ADDR_W'(int'(y) * H_RES + int'(x));
  endfunction

  state_t            state, state_nx;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nx;
  logic [PW-1:0]     clr_colour, clr_colour_nx;
  logic              clr_last;

  logic              rd_in_range, wr_in_range;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic              host_we, clr_we;

  logic [PW-1:0]     mem [DEPTH];
  logic [PW-1:0]     rd_word;
  logic              rd_v1, rd_ok1;
  logic [PW-1:0]     stage1_pixel;

  // Out-of-range coordinates are steered to address 0 so the array is never over-indexed.
  assign rd_in_range = in_range(rd_x, rd_y);
  assign wr_in_range = in_range(wr_x, wr_y);
  assign rd_addr     = rd_in_range ? to_addr(rd_x, rd_y) : '0;
  assign wr_addr     = wr_in_range ? to_addr(wr_x, wr_y) : '0;

  assign clear_busy  = (state == S_CLEAR);
  assign wr_ready    = !clear_busy;
  assign clr_we      = clear_busy;
  assign host_we     = wr_valid && wr_ready && wr_in_range;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx      = state;
    clr_cnt_nx    = clr_cnt;
    clr_colour_nx = clr_colour;
    clr_last      = 1'b0;
    case (state)
      S_IDLE: begin
        if (clear_req) begin
          state_nx      = S_CLEAR;
          clr_cnt_nx    = '0;
          clr_colour_nx = clear_colour;
        end
      end
      S_CLEAR: begin
        clr_last   = (clr_cnt == ADDR_W'(DEPTH - 1));
        clr_cnt_nx = clr_last ? '0 : clr_cnt + ADDR_W'(1);
        if (clr_last) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RESET_STATE;
      clr_cnt    <= '0;
      clr_colour <= '0;
      clear_done <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      state      <= state_nx;
      clr_cnt    <= clr_cnt_nx;
      clr_colour <= clr_colour_nx;
      clear_done <= clr_last;
      wr_err     <= wr_valid && wr_ready && !wr_in_range;
    end
  end

  // NOTE: the pixel array and its read word are deliberately not reset; a RAM macro has no reset.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= clr_colour;
    end else if (host_we) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_mask[c]) mem[wr_addr][c*BPP +: BPP] <= wr_pixel[c*BPP +: BPP];
      end
    end
    if (rd_en) rd_word <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_v1  <= 1'b0;
      rd_ok1 <= 1'b0;
    end else begin
      rd_v1  <= rd_en;
      rd_ok1 <= rd_en && rd_in_range;
    end
  end

  // Gating by the in-range flag forces zero for out-of-range reads and while idle or in reset.
  assign stage1_pixel = rd_ok1 ? rd_word : '0;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic          rd_v2;
      logic [PW-1:0] rd_pixel2;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rd_v2     <= 1'b0;
          rd_pixel2 <= '0;
        end else begin
          rd_v2     <= rd_v1;
          rd_pixel2 <= stage1_pixel;
        end
      end
      assign rd_valid = rd_v2;
      assign rd_pixel = rd_pixel2;
    end else begin : g_direct
      assign rd_valid = rd_v1;
      assign rd_pixel = stage1_pixel;
    end
  endgenerate

endmodule

// File: tb/tb_vram_pixel_store.sv
// Scoreboard bench for vram_pixel_store: reads push expected pixels and due cycles,
// an independent monitor pops and compares whenever rd_valid is presented.
module tb_vram_pixel_store;

  localparam int H_RES   = 128;
  localparam int V_RES   = 96;
  localparam int OUT_REG = 0;
  localparam int DEPTH   = H_RES * V_RES;

  logic       clk = 1'b0;
  logic       reset;
  logic       rd_en;
  logic [6:0] rd_x, rd_y;
  logic       rd_valid;
  logic [2:0] rd_pixel;
  logic       wr_valid, wr_ready;
  logic [6:0] wr_x, wr_y;
  logic [2:0] wr_mask, wr_pixel;
  logic       wr_err;
  logic       clear_req;
  logic [2:0] clear_colour;
  logic       clear_busy, clear_done;

  vram_pixel_store #(
    .H_RES(H_RES), .V_RES(V_RES), .BPP(1), .CHANNELS(3),
    .OUT_REG(OUT_REG), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid), .rd_pixel(rd_pixel),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_mask(wr_mask), .wr_pixel(wr_pixel), .wr_err(wr_err),
    .clear_req(clear_req), .clear_colour(clear_colour),
    .clear_busy(clear_busy), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] pix;
    int         due;
  } rd_exp_t;

  rd_exp_t sb[$];
  rd_exp_t mon_e;
  int      cyc = 0;
  int      n_checks = 0;
  int      n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rd_valid) begin
      if (sb.size() == 0) begin
        check("rd_valid without request", 32'(rd_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rd_pixel", 32'(rd_pixel), 32'(mon_e.pix));
        check("rd_latency", cyc, mon_e.due);
      end
    end
  end

  task automatic rd(input int x, input int y, input logic [2:0] exp);
    @(negedge clk);
    rd_en = 1'b1;
    rd_x  = 7'(x);
    rd_y  = 7'(y);
    sb.push_back('{pix: exp, due: cyc + 1 + OUT_REG});
  endtask

  task automatic drain();
    @(negedge clk);
    rd_en = 1'b0;
    for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clk);
    check("scoreboard drained", sb.size(), 0);
  endtask

  task automatic readback_all(input logic [2:0] exp);
    for (int y = 0; y < V_RES; y++)
      for (int x = 0; x < H_RES; x++)
        rd(x, y, exp);
    drain();
  endtask

  task automatic wr(input string name, input int x, input int y, input logic [2:0] mask,
                    input logic [2:0] pix, input logic exp_err);
    @(negedge clk);
    check({name, " wr_ready"}, 32'(wr_ready), 32'd1);
    wr_valid = 1'b1;
    wr_x     = 7'(x);
    wr_y     = 7'(y);
    wr_mask  = mask;
    wr_pixel = pix;
    @(negedge clk);
    wr_valid = 1'b0;
    check({name, " wr_err"}, 32'(wr_err), 32'(exp_err));
    @(negedge clk);
    check({name, " wr_err pulse end"}, 32'(wr_err), 32'd0);
  endtask

  // Counts busy / not-ready cycles of a running clear; optionally fires a clear_req and a read mid-way.
  task automatic run_clear(input int req_at, input int rd_at, input logic [2:0] rd_exp,
                           output int busy, output int not_ready, output int dones);
    busy = 0; not_ready = 0; dones = 0;
    for (int i = 0; i < DEPTH + 4000 && clear_busy; i++) begin
      busy++;
      if (!wr_ready) not_ready++;
      if (clear_done) dones++;
      clear_req = (i == req_at);
      if (i == req_at) clear_colour = 3'b011;
      rd_en = (i == rd_at);
      if (i == rd_at) begin
        rd_x = 7'd0;
        rd_y = 7'd0;
        sb.push_back('{pix: rd_exp, due: cyc + 1 + OUT_REG});
      end
      @(negedge clk);
    end
    clear_req = 1'b0;
    rd_en     = 1'b0;
    repeat (3) begin
      if (clear_done) dones++;
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " rd_valid"},   32'(rd_valid),   32'd0);
    check({name, " rd_pixel"},   32'(rd_pixel),   32'd0);
    check({name, " wr_err"},     32'(wr_err),     32'd0);
    check({name, " clear_done"}, 32'(clear_done), 32'd0);
    check({name, " clear_busy"}, 32'(clear_busy), 32'd1);
    check({name, " wr_ready"},   32'(wr_ready),   32'd0);
  endtask

  int busy, not_ready, dones;

  initial begin
    reset = 1'b0;
    rd_en = 1'b0; rd_x = '0; rd_y = '0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_mask = '0; wr_pixel = '0;
    clear_req = 1'b0;
    clear_colour = 3'b111;  // must be ignored: reset-started clear fills with 0
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // T1: automatic clear after reset release
    reset = 1'b1;
    run_clear(-1, -1, 3'b000, busy, not_ready, dones);
    check("T1 clear_busy cycles", busy, DEPTH);
    check("T1 clear_done pulses", dones, 1);
    readback_all(3'b000);

    // T2: full write then read
    wr("T2", 5, 3, 3'b111, 3'b101, 1'b0);
    rd(5, 3, 3'b101);
    drain();

    // T3: masked writes keep unmasked channels
    wr("T3a", 5, 3, 3'b010, 3'b010, 1'b0);
    wr("T3b", 6, 3, 3'b001, 3'b111, 1'b0);
    rd(5, 3, 3'b111);
    rd(6, 3, 3'b001);
    drain();

    // Same-address read and write in one cycle returns the old data
    @(negedge clk);
    wr_valid = 1'b1; wr_x = 7'd7; wr_y = 7'd3; wr_mask = 3'b111; wr_pixel = 3'b011;
    rd_en = 1'b1; rd_x = 7'd7; rd_y = 7'd3;
    sb.push_back('{pix: 3'b000, due: cyc + 1 + OUT_REG});
    rd(7, 3, 3'b011);
    wr_valid = 1'b0;
    drain();

    // T4: out-of-range write and reads
    wr("T4 oob", 5, 100, 3'b111, 3'b010, 1'b1);
    rd(5, 3, 3'b111);
    rd(0, 96, 3'b000);
    rd(5, 100, 3'b000);
    rd(127, 95, 3'b000);
    drain();

    // T5: clear to 3'b110 started together with a host write and a read
    @(negedge clk);
    check("T5 wr_ready before clear", 32'(wr_ready), 32'd1);
    clear_req = 1'b1; clear_colour = 3'b110;
    wr_valid = 1'b1; wr_x = 7'd10; wr_y = 7'd10; wr_mask = 3'b111; wr_pixel = 3'b001;
    rd_en = 1'b1; rd_x = 7'd5; rd_y = 7'd3;
    sb.push_back('{pix: 3'b111, due: cyc + 1 + OUT_REG});
    @(negedge clk);
    clear_req = 1'b0; wr_valid = 1'b0; rd_en = 1'b0;
    check("T5 wr_err on concurrent write", 32'(wr_err), 32'd0);
    run_clear(6000, 100, 3'b110, busy, not_ready, dones);
    check("T5 clear_busy cycles", busy, DEPTH);
    check("T5 wr_ready low cycles", not_ready, DEPTH);
    check("T5 clear_done pulses", dones, 1);
    readback_all(3'b110);

    // T6: reset in the middle of a clear restarts it with colour 0
    @(negedge clk);
    clear_req = 1'b1; clear_colour = 3'b101;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (5000) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("T6 reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_clear(-1, -1, 3'b000, busy, not_ready, dones);
    check("T6 clear_busy cycles", busy, DEPTH);
    check("T6 clear_done pulses", dones, 1);
    rd(0, 0, 3'b000);
    rd(64, 40, 3'b000);
    rd(127, 95, 3'b000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
